// File: rtl/operand_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_ctrl_pkg
// Brief    : Shared widths and FSM state encoding for the operand fetch block
// Revision : 1.0 - initial release
// ============================================================================
package operand_fetch_ctrl_pkg;

    localparam int c_DATA_W = 16;
    localparam int c_REG_AW = 3;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_READ_A   = 3'd1;
    localparam logic [2:0] c_ST_READ_B   = 3'd2;
    localparam logic [2:0] c_ST_ISSUE    = 3'd3;
    localparam logic [2:0] c_ST_WAIT_RES = 3'd4;
    localparam logic [2:0] c_ST_WRITE    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/operand_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_ctrl_if
// Brief    : Request, register-file, execute and result signals of the block
// Revision : 1.0 - initial release
// ============================================================================
interface operand_fetch_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [REG_AW-1:0] req_rn;
    logic [REG_AW-1:0] req_rm;
    logic [REG_AW-1:0] req_rd;
    logic              req_two_op;
    logic              req_wb;
    logic [REG_AW-1:0] rf_readnum;
    logic [DATA_W-1:0] rf_data_out;
    logic [REG_AW-1:0] rf_writenum;
    logic              rf_write;
    logic [DATA_W-1:0] rf_data_in;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_valid;
    logic              op_ready;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic              busy;

    // master is the fetch controller itself
    modport master (
        input  req_valid, req_rn, req_rm, req_rd, req_two_op, req_wb,
        input  rf_data_out, op_ready, res_valid, res_data,
        output req_ready, rf_readnum, rf_writenum, rf_write, rf_data_in,
        output op_a, op_b, op_valid, res_ready, busy
    );

    modport slave (
        output req_valid, req_rn, req_rm, req_rd, req_two_op, req_wb,
        output rf_data_out, op_ready, res_valid, res_data,
        input  req_ready, rf_readnum, rf_writenum, rf_write, rf_data_in,
        input  op_a, op_b, op_valid, res_ready, busy
    );
endinterface
`default_nettype wire

// File: rtl/operand_fetch_ctrl_dffe_arn.sv
`default_nettype none
// ============================================================================
// Module   : dffe_arn
// Brief    : Enabled register with asynchronous active-low clear
// Revision : 1.0 - initial release
// ============================================================================
module dffe_arn #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/operand_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_ctrl
// Brief    : Fetches two operands over one RF read port, issues them, and
//            optionally writes the execute result back
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch_ctrl
    import operand_fetch_ctrl_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int REG_AW = c_REG_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    operand_fetch_ctrl_if.master bus
);

    localparam int c_REQ_W = 3 * REG_AW + 2;

    logic [2:0]        r_state;
    logic              r_req_ready;
    logic              r_op_valid;
    logic              r_res_ready;
    logic              r_rf_write;
    logic              r_busy;
    logic [REG_AW-1:0] r_readnum;
    logic [REG_AW-1:0] r_writenum;

    logic [c_REQ_W-1:0] r_req_q;
    logic [c_REQ_W-1:0] w_req_d;
    logic [REG_AW-1:0]  w_rm_q;
    logic [REG_AW-1:0]  w_rd_q;
    logic               w_two_op_q;
    logic               w_wb_q;

    logic [DATA_W-1:0]  r_op_a;
    logic [DATA_W-1:0]  r_op_b;
    logic [DATA_W-1:0]  r_result;
    logic [DATA_W-1:0]  w_op_b_d;
    logic               w_req_en;
    logic               w_op_a_en;
    logic               w_op_b_en;
    logic               w_res_en;

    assign w_req_d    = {bus.req_rn, bus.req_rm, bus.req_rd, bus.req_two_op, bus.req_wb};
    assign w_rm_q     = r_req_q[2*REG_AW+1:REG_AW+2];
    assign w_rd_q     = r_req_q[REG_AW+1:2];
    assign w_two_op_q = r_req_q[1];
    assign w_wb_q     = r_req_q[0];

    assign w_req_en  = (r_state == c_ST_IDLE) && bus.req_valid;
    assign w_op_a_en = (r_state == c_ST_READ_A);
    // Single-operand requests load zero into op_b while op_a is being read
    assign w_op_b_en = (r_state == c_ST_READ_B) || ((r_state == c_ST_READ_A) && !w_two_op_q);
    assign w_op_b_d  = (r_state == c_ST_READ_B) ? bus.rf_data_out : '0;
    assign w_res_en  = (r_state == c_ST_WAIT_RES) && bus.res_valid;

    dffe_arn #(.WIDTH(c_REQ_W)) u_req_q (
        .clk(clk), .rst_n(rst_n), .i_en(w_req_en), .i_d(w_req_d), .o_q(r_req_q)
    );
    dffe_arn #(.WIDTH(DATA_W)) u_op_a (
        .clk(clk), .rst_n(rst_n), .i_en(w_op_a_en), .i_d(bus.rf_data_out), .o_q(r_op_a)
    );
    dffe_arn #(.WIDTH(DATA_W)) u_op_b (
        .clk(clk), .rst_n(rst_n), .i_en(w_op_b_en), .i_d(w_op_b_d), .o_q(r_op_b)
    );
    dffe_arn #(.WIDTH(DATA_W)) u_result (
        .clk(clk), .rst_n(rst_n), .i_en(w_res_en), .i_d(bus.res_data), .o_q(r_result)
    );

    // Outputs are registered alongside the state so they depend on state only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_req_ready <= 1'b1;
            r_op_valid  <= 1'b0;
            r_res_ready <= 1'b0;
            r_rf_write  <= 1'b0;
            r_busy      <= 1'b0;
            r_readnum   <= '0;
            r_writenum  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_state     <= c_ST_READ_A;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_readnum   <= bus.req_rn;
                    end
                end
                c_ST_READ_A: begin
                    if (w_two_op_q) begin
                        r_state   <= c_ST_READ_B;
                        r_readnum <= w_rm_q;
                    end else begin
                        r_state    <= c_ST_ISSUE;
                        r_readnum  <= '0;
                        r_op_valid <= 1'b1;
                    end
                end
                c_ST_READ_B: begin
                    r_state    <= c_ST_ISSUE;
                    r_readnum  <= '0;
                    r_op_valid <= 1'b1;
                end
                c_ST_ISSUE: begin
                    if (bus.op_ready) begin
                        r_op_valid <= 1'b0;
                        if (w_wb_q) begin
                            r_state     <= c_ST_WAIT_RES;
                            r_res_ready <= 1'b1;
                        end else begin
                            r_state     <= c_ST_IDLE;
                            r_req_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end
                    end
                end
                c_ST_WAIT_RES: begin
                    if (bus.res_valid) begin
                        r_state     <= c_ST_WRITE;
                        r_res_ready <= 1'b0;
                        r_rf_write  <= 1'b1;
                        r_writenum  <= w_rd_q;
                    end
                end
                c_ST_WRITE: begin
                    r_state     <= c_ST_IDLE;
                    r_rf_write  <= 1'b0;
                    r_writenum  <= '0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_op_valid  <= 1'b0;
                    r_res_ready <= 1'b0;
                    r_rf_write  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_readnum   <= '0;
                    r_writenum  <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.op_valid    = r_op_valid;
    assign bus.res_ready   = r_res_ready;
    assign bus.rf_write    = r_rf_write;
    assign bus.busy        = r_busy;
    assign bus.rf_readnum  = r_readnum;
    assign bus.rf_writenum = r_writenum;
    assign bus.rf_data_in  = r_result;
    assign bus.op_a        = r_op_a;
    assign bus.op_b        = r_op_b;

endmodule
`default_nettype wire
